// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg: shared types and constants for the sequential divider.
//   DIV_WIDTH    default operand width
//   DIV_STEP_W   step-counter width for DIV_WIDTH
//   div_state_e  controller states (FIXUP only when DIV_SIGNED_EN is defined)
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands/results).
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 8;

    // Width of a counter that must hold the values 0 .. w-1.
    function automatic int div_step_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int DIV_STEP_W = div_step_w(DIV_WIDTH);

`ifdef DIV_SIGNED_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2,
        FIXUP = 2'd3
    } div_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2
    } div_state_e;
`endif

endpackage

// File: rtl/div_seq_if.sv
// ---------------------------------------------------------------------------
// div_seq_if: operand and result handshakes of the sequential divider.
//   in_valid/in_ready   operand handshake (dividend, divisor)
//   out_valid/out_ready result handshake (quotient, remainder, div_by_zero)
// master: producer of operands / consumer of results. slave: the divider.
// ---------------------------------------------------------------------------
interface div_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step: one combinational restoring-division stage.
//   rem_i      partial remainder entering the stage (always < divisor)
//   dvd_bit_i  next dividend bit shifted into the remainder
//   divisor_i  divisor
//   rem_o      partial remainder leaving the stage
//   q_bit_o    quotient bit produced by this stage
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);
    // The shifted remainder needs one extra bit so max operands cannot overflow.
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;

    // Shift in the next dividend bit, then subtract the divisor if it fits.
    always_comb begin
        shifted_s = {rem_i, dvd_bit_i};
        // When the subtraction is taken the true difference is < divisor, so
        // the low WIDTH bits carry the whole result.
        diff_s    = shifted_s[WIDTH-1:0] - divisor_i;
        if (shifted_s >= {1'b0, divisor_i}) begin
            q_bit_o = 1'b1;
            rem_o   = diff_s;
        end else begin
            q_bit_o = 1'b0;
            rem_o   = shifted_s[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq: sequential restoring divider, one quotient bit per clock.
//   clk  clock (posedge)          rst  synchronous active-high reset
//   bus  div_seq_if.slave: operand handshake in, result handshake out
// Unsigned latency WIDTH+1 cycles, divide-by-zero 1 cycle.
// Optional macro DIV_SIGNED_EN: two's-complement operands, an extra FIXUP
// cycle applies signs to the magnitude result (latency WIDTH+2).
// ---------------------------------------------------------------------------
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int SW = div_step_w(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;       // latched dividend (magnitude)
    logic [WIDTH-1:0] dvs_q, dvs_d;       // latched divisor (magnitude)
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;       // quotient being assembled
    logic [SW-1:0]    step_q, step_d;     // dividend bit processed this cycle
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             dvd_bit_s;
    logic             q_bit_s;
    logic [WIDTH-1:0] step_rem_s;

`ifdef DIV_SIGNED_EN
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    // Magnitude of a two's-complement value; the most-negative value maps to
    // its correct unsigned magnitude (e.g. 0x80 -> 128).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction
`endif

    assign dvd_bit_s = dvd_q[step_q];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_bit_s),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_s),
        .q_bit_o   (q_bit_s)
    );

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

    // Next-state and next-output logic; handshake outputs are registered
    // from the state being entered.
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        step_d      = step_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    rem_d      = '0;
                    quo_d      = '0;
                    step_d     = SW'(WIDTH - 1);
                    if (bus.divisor == '0) begin
                        // Divide-by-zero skips the datapath entirely.
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = CALC;
`ifdef DIV_SIGNED_EN
                        dvd_d     = mag(bus.dividend);
                        dvs_d     = mag(bus.divisor);
                        neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_rem_d = bus.dividend[WIDTH-1];
`else
                        dvd_d = bus.dividend;
                        dvs_d = bus.divisor;
`endif
                    end
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            CALC: begin
                rem_d         = step_rem_s;
                quo_d[step_q] = q_bit_s;
                if (step_q == '0) begin
`ifdef DIV_SIGNED_EN
                    state_d = FIXUP;
`else
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    quotient_d  = quo_d;
                    remainder_d = step_rem_s;
                    dbz_d       = 1'b0;
`endif
                end else begin
                    step_d = step_q - 1'b1;
                end
            end
`ifdef DIV_SIGNED_EN
            FIXUP: begin
                // Quotient truncates toward zero; remainder follows the dividend.
                state_d     = DONE;
                out_valid_d = 1'b1;
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                dbz_d       = 1'b0;
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end
endmodule
